// File: rtl/pathfinding_pkg.sv
// -----------------------------------------------------------------------------
// pathfinding_pkg
// Shared types and constants for the display path of the pathfinding board.
//   NUM_DIGITS  : number of seven-segment displays (HEX0..HEX5)
//   BCD_W       : width of one BCD digit
//   bcd_digit_t : one BCD digit
//   bcd_bus_t   : packed bus of all display digits, digit 0 least significant;
//                 the board top level uses it to carry digits_out to
//                 Seven_Seg_Data
//   fmt_state_t : states of the binary-to-BCD formatter
// -----------------------------------------------------------------------------
package pathfinding_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_bus_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fmt_state_t;

endpackage : pathfinding_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Double-dabble correction for one BCD nibble: adds 3 when the nibble is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit. The largest legal input is 9, giving 12, so the result always
// fits in four bits.
//   digit_in  : BCD nibble before correction
//   digit_out : corrected nibble
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import pathfinding_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    // Add-3 correction for nibbles of 5 and above.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule : bcd_digit_adjust

// File: rtl/bcd_display_formatter.sv
// -----------------------------------------------------------------------------
// bcd_display_formatter
// Sequential binary-to-BCD converter feeding the seven-segment decoders.
// A value accepted over a valid/ready handshake is converted with the
// shift-add-3 algorithm, one bit per clock, and the finished digits are loaded
// into digits_out in one step so the displays never show partial results.
// Values above MAX_VAL saturate to MAX_VAL and raise overflow.
//
// Ports:
//   CLOCK_50   : system clock
//   reset_n    : asynchronous active-low reset
//   in_valid   : bin_in is valid this cycle
//   in_ready   : block can accept a new value (IDLE)
//   bin_in     : unsigned binary value to display
//   digits_out : registered BCD digits, digit i in bits [4i+3:4i]
//   done       : one-cycle pulse when digits_out has just been updated
//   overflow   : last accepted value exceeded MAX_VAL (sticky until next accept)
//
// Timing: a value accepted at edge k appears on digits_out at edge
// k+BIN_W+1, together with done; in_ready is high again in that cycle, so a
// new value can be taken back-to-back.
// -----------------------------------------------------------------------------
module bcd_display_formatter
    import pathfinding_pkg::*;
#(
    parameter int BIN_W   = 20,
    parameter int DIGITS  = 6,
    parameter int MAX_VAL = 999999
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  done,
    output logic                  overflow
);

    localparam int                SCR_W    = BCD_W * DIGITS;
    localparam int                CNT_W    = $clog2(BIN_W);
    localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BIN_W - 1);

    fmt_state_t          state_r;
    fmt_state_t          state_next_s;
    logic                accept_s;
    logic                over_s;
    logic [BIN_W-1:0]    bin_sat_s;
    logic [BIN_W-1:0]    bin_r;
    logic [SCR_W-1:0]    scratch_r;
    logic [SCR_W-1:0]    scratch_adj_s;
    logic [SCR_W-1:0]    scratch_next_s;
    logic [BIN_W-1:0]    bin_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [SCR_W-1:0]    digits_r;
    logic                done_r;
    logic                overflow_r;
    logic                in_ready_r;

    // One add-3 corrector per scratch nibble.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adjust
            bcd_digit_t adj_digit_s;

            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_r[BCD_W*g +: BCD_W]),
                .digit_out (adj_digit_s)
            );

            assign scratch_adj_s[BCD_W*g +: BCD_W] = adj_digit_s;
        end
    endgenerate

    // Correct first, then shift {scratch, binary} left by one bit.
    always_comb begin
        scratch_next_s = {scratch_adj_s[SCR_W-2:0], bin_r[BIN_W-1]};
        bin_next_s     = {bin_r[BIN_W-2:0], 1'b0};
    end

    // Input saturation: anything above MAX_VAL is displayed as MAX_VAL.
    always_comb begin
        over_s    = 1'b0;
        bin_sat_s = bin_in;
        if (bin_in > MAX_BIN) begin
            over_s    = 1'b1;
            bin_sat_s = MAX_BIN;
        end else begin
            over_s    = 1'b0;
            bin_sat_s = bin_in;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic and accept strobe.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = SHIFT;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                    accept_s     = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Conversion datapath and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bin_r      <= '0;
            scratch_r  <= '0;
            cnt_r      <= '0;
            digits_r   <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            done_r     <= 1'b0;
            // Ready is a registered copy of "will be IDLE next cycle".
            in_ready_r <= (state_next_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        bin_r      <= bin_sat_s;
                        scratch_r  <= '0;
                        cnt_r      <= '0;
                        overflow_r <= over_s;
                    end else begin
                        bin_r      <= bin_r;
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_next_s;
                    bin_r     <= bin_next_s;
                    cnt_r     <= cnt_r + CNT_W'(1);
                end
                DONE: begin
                    digits_r <= scratch_r;
                    done_r   <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign digits_out = digits_r;
    assign done       = done_r;
    assign overflow   = overflow_r;

endmodule : bcd_display_formatter

// File: tb/tb_bcd_display_formatter.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_formatter
// Self-checking bench for bcd_display_formatter. Expected digits come from
// decimal division of the saturated value.
// -----------------------------------------------------------------------------
module tb_bcd_display_formatter;

    logic        CLOCK_50;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] bin_in;
    logic [23:0] digits_out;
    logic        done;
    logic        overflow;

    int          err_cnt;
    int          chk_cnt;
    logic [23:0] shown;    // what the displays should currently show

    bcd_display_formatter dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bin_in     (bin_in),
        .digits_out (digits_out),
        .done       (done),
        .overflow   (overflow)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of min(v, 999999).
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        int unsigned s;
        logic [23:0] r;
        s = (v > 999999) ? 999999 : v;
        r = 24'h0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge CLOCK_50); #1;
            n++;
        end
        check_eq("ready_before_send", 32'(in_ready), 32'd1);
    endtask

    // Counts edges after acceptance until done; checks digits hold meanwhile.
    task automatic wait_done(output int lat, output logic stable);
        logic seen;
        seen   = 1'b0;
        stable = 1'b1;
        lat    = 0;
        if (digits_out !== shown) stable = 1'b0;
        while (!seen && lat < 30) begin
            @(posedge CLOCK_50); #1;
            lat++;
            if (done) seen = 1'b1;
            else if (digits_out !== shown) stable = 1'b0;
        end
    endtask

    // Full conversion with all checks on the result.
    task automatic convert(input logic [19:0] val);
        int   lat;
        logic stable;
        wait_ready();
        in_valid = 1'b1;
        bin_in   = val;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        bin_in   = 20'($urandom);
        wait_done(lat, stable);
        check_eq("latency", 32'(lat), 32'd21);
        check_eq("digits", 32'(digits_out), 32'(ref_bcd(32'(val))));
        check_eq("overflow", 32'(overflow), 32'(val > 20'd999999));
        check_eq("hold_during_conv", 32'(stable), 32'd1);
        check_eq("ready_in_done", 32'(in_ready), 32'd1);
        shown = ref_bcd(32'(val));
        @(posedge CLOCK_50); #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int   lat;
        int   cnt_done;
        logic stable;
        err_cnt  = 0;
        chk_cnt  = 0;
        shown    = 24'h0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        bin_in   = 20'd0;

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_eq("rst_digits", 32'(digits_out), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(posedge CLOCK_50); #1;
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // Directed values
        convert(20'd0);
        convert(20'd123456);
        convert(20'd999999);
        convert(20'd1048575);
        convert(20'd1000000);

        // Held in_valid, value changed while busy, then back-to-back accept
        wait_ready();
        in_valid = 1'b1;
        bin_in   = 20'd42;
        @(posedge CLOCK_50); #1;
        bin_in = 20'd7;
        wait_done(lat, stable);
        check_eq("b2b_latency0", 32'(lat), 32'd21);
        check_eq("b2b_digits0", 32'(digits_out), 32'h000042);
        check_eq("b2b_hold0", 32'(stable), 32'd1);
        check_eq("b2b_ready_done", 32'(in_ready), 32'd1);
        shown = 24'h000042;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        check_eq("b2b_accepted", 32'(in_ready), 32'd0);
        wait_done(lat, stable);
        check_eq("b2b_latency1", 32'(lat), 32'd21);
        check_eq("b2b_digits1", 32'(digits_out), 32'h000007);
        check_eq("b2b_hold1", 32'(stable), 32'd1);
        shown = 24'h000007;
        @(posedge CLOCK_50); #1;

        // Reset in the middle of a conversion
        convert(20'd1048000);
        wait_ready();
        in_valid = 1'b1;
        bin_in   = 20'd555555;
        @(posedge CLOCK_50); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_digits", 32'(digits_out), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        shown = 24'h0;
        cnt_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLOCK_50); #1;
            if (done) cnt_done++;
        end
        check_eq("midrst_no_done", 32'(cnt_done), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_digits_kept", 32'(digits_out), 32'd0);
        convert(20'd314);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            convert(20'($urandom_range(0, 1048575)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_bcd_display_formatter
